// File: rtl/ahbsched_pkg.sv
// Shared definitions for the AHB transfer scheduler.
//   state_e         : scheduler FSM states
//   Size*           : SIZE input codes (byte / half / word)
//   Htrans*         : HTRANS codes used to qualify accepted beats
//   BoundaryDefault : default address boundary a burst must not cross (bytes)
//   MaxBurstDefault : default burst-length saturation value (beats)
package ahbsched_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StRun   = 2'd2,
      StDone  = 2'd3
   } state_e;

   localparam logic [2:0] SizeB8  = 3'd0;
   localparam logic [2:0] SizeB16 = 3'd1;
   localparam logic [2:0] SizeB32 = 3'd2;

   localparam logic [1:0] HtransIdle = 2'b00;
   localparam logic [1:0] HtransNseq = 2'b10;
   localparam logic [1:0] HtransSeq  = 2'b11;

   localparam int unsigned BoundaryDefault = 1024;
   localparam int unsigned MaxBurstDefault = 16;

   // Channel encoding, also the value driven on WRITE.
   localparam logic ChanRd = 1'b0;
   localparam logic ChanWr = 1'b1;

   // Byte-address shift per beat; undefined size codes behave as word.
   function automatic logic [1:0] size_shift(input logic [2:0] size);
      logic [1:0] sh;
      case (size)
         SizeB8:  sh = 2'd0;
         SizeB16: sh = 2'd1;
         SizeB32: sh = 2'd2;
         default: sh = 2'd2;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/ahbsched_rr_arb.sv
// Two-way round-robin arbiter for the scheduler's read/write job channels.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   soft_rst_i : synchronous soft reset
//   req_i      : requests, bit 0 = read, bit 1 = write
//   take_i     : grant is consumed this cycle; records the winner as last grant
//   gnt_o      : one-hot grant (combinational), zero when nothing is requested
module ahbsched_rr_arb
   import ahbsched_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       soft_rst_i,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic [1:0] gnt_o
);

   logic last_q, last_d;

   always_comb begin
      gnt_o  = req_i;
      // On a tie the channel that did not win last time goes first.
      if (req_i == 2'b11) begin
         gnt_o = (last_q == ChanWr) ? 2'b01 : 2'b10;
      end
      last_d = last_q;
      if (take_i && (gnt_o != 2'b00)) begin
         last_d = gnt_o[1];
      end
   end

   // Reset to "write granted last" so read wins the first tie.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || soft_rst_i) begin
         last_q <= ChanWr;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ahbsched.sv
// AHB transfer scheduler: arbitrates read/write jobs round-robin, splits each job
// into bursts of at most P_MAX_BURST beats that never cross a P_BOUNDARY-byte
// boundary, drives the master controls and counts accepted beats.
//   I_AHBSCHED_HCLK / HRESET_N     : clock, synchronous active-low reset
//   I_AHBSCHED_RESET               : synchronous soft reset, aborts any job
//   I_AHBSCHED_SIZE                : 0 byte, 1 half, else word
//   I_AHBSCHED_{RD,WR}_REQ/ADDR/LEN: job requests, held until the matching ACK
//   O_AHBSCHED_{RD,WR}_ACK         : one-cycle job-complete pulses
//   I_AHBSCHED_HREADY / HTRANS     : bus handshake used to count accepted beats
//   O_AHBSCHED_ADDR/COUNT/WRITE    : current burst controls, valid from START
//   O_AHBSCHED_START / STOP        : burst start pulse / end-of-job pulse
//   O_AHBSCHED_BUSY                : high whenever the FSM is not idle
module ahbsched
   import ahbsched_pkg::*;
#(
   parameter int unsigned P_MAX_BURST = MaxBurstDefault,
   // Must be a power of two.
   parameter int unsigned P_BOUNDARY  = BoundaryDefault
) (
   input  logic        I_AHBSCHED_HCLK,
   input  logic        I_AHBSCHED_HRESET_N,
   input  logic        I_AHBSCHED_RESET,
   input  logic [2:0]  I_AHBSCHED_SIZE,
   input  logic        I_AHBSCHED_RD_REQ,
   input  logic [31:0] I_AHBSCHED_RD_ADDR,
   input  logic [4:0]  I_AHBSCHED_RD_LEN,
   output logic        O_AHBSCHED_RD_ACK,
   input  logic        I_AHBSCHED_WR_REQ,
   input  logic [31:0] I_AHBSCHED_WR_ADDR,
   input  logic [4:0]  I_AHBSCHED_WR_LEN,
   output logic        O_AHBSCHED_WR_ACK,
   input  logic        I_AHBSCHED_HREADY,
   input  logic [1:0]  I_AHBSCHED_HTRANS,
   output logic [31:0] O_AHBSCHED_ADDR,
   output logic [4:0]  O_AHBSCHED_COUNT,
   output logic        O_AHBSCHED_WRITE,
   output logic        O_AHBSCHED_START,
   output logic        O_AHBSCHED_STOP,
   output logic        O_AHBSCHED_BUSY
);

   state_e      state_q, state_d;
   logic        chan_q, chan_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  count_q, count_d;
   logic [4:0]  rem_q, rem_d;
   logic [4:0]  beat_q, beat_d;
   logic [1:0]  sh_q, sh_d;

   logic [1:0]  req, gnt;
   logic        take;
   logic [31:0] grant_addr;
   logic [4:0]  grant_len, len_eff;
   logic [31:0] next_addr;
   logic [31:0] sel_addr;
   logic [4:0]  sel_rem;
   logic [1:0]  sel_sh;
   logic [31:0] bnd_off, btb_raw;
   logic [4:0]  btb, burst;
   logic        beat_ok;
   logic [4:0]  beat_inc;

   assign req = {I_AHBSCHED_WR_REQ, I_AHBSCHED_RD_REQ};

   ahbsched_rr_arb u_arb (
      .clk_i      (I_AHBSCHED_HCLK),
      .rst_ni     (I_AHBSCHED_HRESET_N),
      .soft_rst_i (I_AHBSCHED_RESET),
      .req_i      (req),
      .take_i     (take),
      .gnt_o      (gnt)
   );

   assign grant_addr = gnt[1] ? I_AHBSCHED_WR_ADDR : I_AHBSCHED_RD_ADDR;
   assign grant_len  = gnt[1] ? I_AHBSCHED_WR_LEN  : I_AHBSCHED_RD_LEN;
   assign next_addr  = addr_q + (32'(count_q) << sh_q);
   assign beat_ok    = I_AHBSCHED_HREADY &&
                       ((I_AHBSCHED_HTRANS == HtransNseq) || (I_AHBSCHED_HTRANS == HtransSeq));
   assign beat_inc   = beat_q + 5'd1;

   always_comb begin
      len_eff = grant_len;
      if (32'(grant_len) > P_MAX_BURST) begin
         len_eff = 5'(P_MAX_BURST);
      end
   end

   // One burst sizer serves both the first burst (from the granted request) and
   // every follow-on burst (from the advanced address and remaining beats).
   always_comb begin
      if (state_q == StIdle) begin
         sel_addr = grant_addr;
         sel_rem  = len_eff;
         sel_sh   = size_shift(I_AHBSCHED_SIZE);
      end else begin
         sel_addr = next_addr;
         sel_rem  = rem_q;
         sel_sh   = sh_q;
      end
      bnd_off = sel_addr & (P_BOUNDARY - 32'd1);
      btb_raw = (P_BOUNDARY - bnd_off) >> sel_sh;
      btb     = (btb_raw > P_MAX_BURST) ? 5'(P_MAX_BURST) : btb_raw[4:0];
      burst   = (sel_rem < btb) ? sel_rem : btb;
   end

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      addr_d  = addr_q;
      count_d = count_q;
      rem_d   = rem_q;
      beat_d  = beat_q;
      sh_d    = sh_q;
      take    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req != 2'b00) begin
               take   = 1'b1;
               chan_d = gnt[1];
               addr_d = grant_addr;
               sh_d   = size_shift(I_AHBSCHED_SIZE);
               beat_d = 5'd0;
               if (len_eff == 5'd0) begin
                  count_d = 5'd0;
                  rem_d   = 5'd0;
                  state_d = StDone;
               end else begin
                  count_d = burst;
                  rem_d   = len_eff - burst;
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            beat_d  = 5'd0;
            state_d = StRun;
         end
         StRun: begin
            if (beat_ok) begin
               if (beat_inc == count_q) begin
                  beat_d = 5'd0;
                  if (rem_q != 5'd0) begin
                     addr_d  = next_addr;
                     count_d = burst;
                     rem_d   = rem_q - burst;
                     state_d = StIssue;
                  end else begin
                     state_d = StDone;
                  end
               end else begin
                  beat_d = beat_inc;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge I_AHBSCHED_HCLK) begin
      if (!I_AHBSCHED_HRESET_N || I_AHBSCHED_RESET) begin
         state_q <= StIdle;
         chan_q  <= ChanRd;
         addr_q  <= 32'd0;
         count_q <= 5'd0;
         rem_q   <= 5'd0;
         beat_q  <= 5'd0;
         sh_q    <= 2'd0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         rem_q   <= rem_d;
         beat_q  <= beat_d;
         sh_q    <= sh_d;
      end
   end

   // All control outputs decode registered state, so they are glitch-free.
   assign O_AHBSCHED_ADDR   = addr_q;
   assign O_AHBSCHED_COUNT  = count_q;
   assign O_AHBSCHED_WRITE  = chan_q;
   assign O_AHBSCHED_START  = (state_q == StIssue);
   assign O_AHBSCHED_STOP   = (state_q == StDone);
   assign O_AHBSCHED_RD_ACK = (state_q == StDone) && (chan_q == ChanRd);
   assign O_AHBSCHED_WR_ACK = (state_q == StDone) && (chan_q == ChanWr);
   assign O_AHBSCHED_BUSY   = (state_q != StIdle);

endmodule
